conv3_acc: RTL and testbench



---
 rtl/conv3_pkg.sv | 26 ++
 rtl/conv3_postproc.sv | 56 +++++
 rtl/conv3_acc.sv | 124 ++++++++++++
 tb/tb_conv3_acc.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv3_pkg.sv
// ============================================================================
// Module   : conv3_pkg
// Brief    : Shared widths, saturation bounds and FSM encoding for conv3_acc.
// Revision : 1.0
// ============================================================================
`default_nettype none

package conv3_pkg;

  localparam int MUL_W     = 22;
  localparam int ACC_W     = 24;
  localparam int OUT_W     = 8;
  localparam int SHIFT_MAX = 23;

  localparam int OUT_MAX   = 127;
  localparam int OUT_MIN   = -128;

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_FIN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/conv3_postproc.sv
// ============================================================================
// Module   : conv3_postproc
// Brief    : Bias add, rounding arithmetic right shift, ReLU and saturation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv3_postproc #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic signed [15:0]      i_bias,
  input  logic        [4:0]       i_shift,
  input  logic                    i_relu_en,
  output logic signed [OUT_W-1:0] o_data,
  output logic                    o_sat
);

  import conv3_pkg::*;

  // One guard bit beyond ACC_W+1 so the rounding offset can never wrap.
  localparam int SW = ACC_W + 2;

  logic        [4:0]    w_shift;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_half;
  logic signed [SW-1:0] w_shr;
  logic signed [SW-1:0] w_res;

  always_comb begin
    w_shift = (i_shift > 5'(SHIFT_MAX)) ? 5'(SHIFT_MAX) : i_shift;
    w_sum   = $signed({{(SW-ACC_W){i_acc[ACC_W-1]}}, i_acc})
            + $signed({{(SW-16){i_bias[15]}}, i_bias});
    w_half  = (w_shift == 5'd0) ? '0 : (SW'(1) <<< (w_shift - 5'd1));
    w_shr   = (w_sum + w_half) >>> w_shift;

    w_res = w_shr;
    if (i_relu_en && (w_shr < 0)) begin
      w_res = '0;
    end

    o_sat  = 1'b0;
    o_data = w_res[OUT_W-1:0];
    if (w_res > SW'(OUT_MAX)) begin
      o_data = OUT_W'(OUT_MAX);
      o_sat  = 1'b1;
    end else if (w_res < SW'(OUT_MIN)) begin
      o_data = OUT_W'(OUT_MIN);
      o_sat  = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv3_acc.sv
// ============================================================================
// Module   : conv3_acc
// Brief    : Accumulates N_STEPS conv3 partial sums per pixel, requantizes and
//            presents the signed result on a valid/ready port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv3_acc #(
  parameter int N_STEPS = 4,
  parameter int MUL_W   = conv3_pkg::MUL_W,
  parameter int ACC_W   = conv3_pkg::ACC_W,
  parameter int OUT_W   = conv3_pkg::OUT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [MUL_W-1:0] mul_plus,
  output logic        [1:0]       sel,
  input  logic signed [15:0]      bias,
  input  logic        [4:0]       shift,
  input  logic                    relu_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  import conv3_pkg::*;

  // N_STEPS must stay within 1..4; the step index is only 2 bits wide.
  localparam logic [1:0] C_LAST = 2'(N_STEPS - 1);

  state_t                  r_state;
  logic        [1:0]       r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_out_data;
  logic                    r_out_sat;

  logic                    w_beat;
  logic signed [ACC_W-1:0] w_mul_ext;
  logic signed [OUT_W-1:0] w_pp_data;
  logic                    w_pp_sat;

  assign w_beat    = in_valid && r_in_ready;
  assign w_mul_ext = $signed({{(ACC_W-MUL_W){mul_plus[MUL_W-1]}}, mul_plus});

  assign in_ready  = r_in_ready;
  assign sel       = r_cnt;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

  conv3_postproc #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_postproc (
    .i_acc     (r_acc),
    .i_bias    (bias),
    .i_shift   (shift),
    .i_relu_en (relu_en),
    .o_data    (w_pp_data),
    .o_sat     (w_pp_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACC;
      r_cnt       <= 2'd0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (clear) begin
      r_state     <= ST_ACC;
      r_cnt       <= 2'd0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_beat) begin
            r_acc <= r_acc + w_mul_ext;
            if (r_cnt == C_LAST) begin
              r_cnt      <= 2'd0;
              r_in_ready <= 1'b0;
              r_state    <= ST_FIN;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        ST_FIN: begin
          r_out_data  <= w_pp_data;
          r_out_sat   <= w_pp_sat;
          r_out_valid <= 1'b1;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_ACC;
          end
        end
        default: begin
          r_state    <= ST_ACC;
          r_cnt      <= 2'd0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv3_acc.sv
// ============================================================================
// Module   : tb_conv3_acc
// Brief    : Directed scoreboard bench for conv3_acc.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_conv3_acc;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic signed [21:0] mul_plus;
  logic        [1:0]  sel;
  logic signed [15:0] bias;
  logic        [4:0]  shift;
  logic               relu_en;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic               out_sat;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  always #5 clk = ~clk;

  conv3_acc #(.N_STEPS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mul_plus  (mul_plus),
    .sel       (sel),
    .bias      (bias),
    .shift     (shift),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: every accepted output is compared against the queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_output: got data %0d, expected no output", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", out_data, $signed(mon_e[7:0]));
        check("out_sat", out_sat, {31'd0, mon_e[8]});
      end
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic beat(input int v, input logic [1:0] es);
    in_valid = 1'b1;
    mul_plus = 22'(v);
    @(negedge clk);
    check("sel", {30'd0, sel}, {30'd0, es});
    check("in_ready", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    mul_plus = 22'sd999;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      mul_plus = 22'sd999;
      @(posedge clk); #1;
    end
  endtask

  task automatic pixel(input int a, input int b, input int c, input int d,
                       input int bi, input int sh, input bit rl,
                       input int ed, input bit es);
    bias    = 16'(bi);
    shift   = 5'(sh);
    relu_en = rl;
    exp_q.push_back({es, 8'(ed)});
    beat(a, 2'd0);
    beat(b, 2'd1);
    beat(c, 2'd2);
    beat(d, 2'd3);
  endtask

  task automatic drain();
    bit got;
    got = 1'b0;
    repeat (20) begin
      if (!got) begin
        @(negedge clk);
        if (out_valid && out_ready) got = 1'b1;
      end
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got no handshake, expected one within 20 cycles");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    mul_plus  = '0;
    bias      = '0;
    shift     = '0;
    relu_en   = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", {31'd0, out_sat}, 0);
    check("rst_sel", {30'd0, sel}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 105 rounded >>2 -> 26; output visible two cycles after the last beat.
    pixel(10, 20, 30, 40, 5, 2, 1'b0, 26, 1'b0);
    @(negedge clk);
    check("fin_out_valid", {31'd0, out_valid}, 0);
    check("fin_in_ready", {31'd0, in_ready}, 0);
    @(negedge clk);
    check("latency_out_valid", {31'd0, out_valid}, 1);
    @(posedge clk); #1;

    pixel(100, 200, -50, 30, 0, 0, 1'b0, 127, 1'b1);
    drain();
    pixel(-100, -100, -100, -100, 0, 0, 1'b1, 0, 1'b0);
    drain();
    pixel(-100, -100, -100, -100, 0, 0, 1'b0, -128, 1'b1);
    drain();
    // negative bias: (80+4)>>>3 = 10
    pixel(10, 20, 30, 40, -20, 3, 1'b0, 10, 1'b0);
    drain();
    // shift 31 clamps to 23: (8388604 + 2^22) >>> 23 = 1
    pixel(2097151, 2097151, 2097151, 2097151, 0, 31, 1'b0, 1, 1'b0);
    drain();
    // negative rounding: (-5+1) >>> 1 = -2
    pixel(-3, -1, -1, 0, 0, 1, 1'b0, -2, 1'b0);
    drain();

    // Backpressure: (10+1)>>>1 = 5 held for 5 cycles.
    out_ready = 1'b0;
    pixel(1, 2, 3, 4, 0, 1, 1'b0, 5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    repeat (5) begin
      check("hold_out_valid", {31'd0, out_valid}, 1);
      check("hold_out_data", out_data, 5);
      check("hold_out_sat", {31'd0, out_sat}, 0);
      check("hold_in_ready", {31'd0, in_ready}, 0);
      check("hold_sel", {30'd0, sel}, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    pixel(5, 5, 5, 5, 0, 0, 1'b0, 20, 1'b0);
    drain();

    // in_valid gaps must not disturb accumulation.
    bias    = '0;
    shift   = '0;
    relu_en = 1'b0;
    exp_q.push_back({1'b0, 8'd10});
    beat(1, 2'd0);
    gap(2);
    beat(2, 2'd1);
    gap(1);
    beat(3, 2'd2);
    beat(4, 2'd3);
    drain();

    // clear after two beats discards them and the beat presented with clear.
    beat(50, 2'd0);
    beat(50, 2'd1);
    clear    = 1'b1;
    in_valid = 1'b1;
    mul_plus = 22'sd50;
    @(negedge clk);
    check("pre_clear_sel", {30'd0, sel}, 2);
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_clear_sel", {30'd0, sel}, 0);
    @(posedge clk); #1;
    pixel(1, 1, 1, 1, 0, 0, 1'b0, 4, 1'b0);
    drain();

    // Asynchronous reset mid-HOLD; this pixel is never handed off.
    out_ready = 1'b0;
    beat(7, 2'd0);
    beat(7, 2'd1);
    beat(7, 2'd2);
    beat(7, 2'd3);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_out_valid", {31'd0, out_valid}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 0);
    check("async_rst_sel", {30'd0, sel}, 0);
    check("async_rst_in_ready", {31'd0, in_ready}, 1);
    check("async_rst_out_data", out_data, 0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    pixel(2, 2, 2, 2, 0, 0, 1'b0, 8, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
